noc_load_sequencer: RTL and testbench

Controller that sequences one traffic experiment on the loader-equipped mesh. It programs per-node loader FIFOs from a command stream, fires start, and waits for every node to report idle (with timeout). It then sweeps each node's PMU counters and emits them as a result stream. It sits between a host/test interface and the mesh, and owns all of the mesh's control inputs.

---
 rtl/noc_load_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_noc_load_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_load_sequencer.sv
// noc_load_sequencer: programs mesh loader FIFOs, runs one traffic
// experiment, then sweeps every node's PMU counters out as a result stream.
module noc_load_sequencer #(
   parameter int N         = 16,
   parameter int NODE_W    = 4,
   parameter int PMU_CNT   = 8,
   parameter int TIMEOUT_W = 20
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic [NODE_W-1:0]      cmd_node_i,
   input  logic [4:0]             cmd_id_i,
   input  logic                   cmd_write_i,
   input  logic [7:0]             cmd_axlen_i,
   input  logic                   go_i,
   input  logic [7:0]             req_depth_i,
   output logic [7:0]             req_depth_o,
   output logic [N-1:0][4:0]      id_o,
   output logic [N-1:0]           write_o,
   output logic [N-1:0][7:0]      axlen_o,
   output logic [N-1:0]           fifo_push_o,
   output logic                   start_o,
   input  logic [N-1:0]           idle_i,
   output logic [N-1:0][4:0]      pmu_addr_o,
   input  logic [N-1:0][63:0]     pmu_data_i,
   output logic                   res_valid_o,
   input  logic                   res_ready_i,
   output logic [NODE_W-1:0]      res_node_o,
   output logic [4:0]             res_addr_o,
   output logic [63:0]            res_data_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   timeout_o,
   output logic                   err_o
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      RUN,
      DUMP_ADDR,
      DUMP_WAIT,
      DUMP_OUT,
      DONE
   } state_t;

   // Timeout fires on the increment that makes the counter all-ones.
   localparam logic [TIMEOUT_W-1:0] TMO_LAST =
      {{(TIMEOUT_W-1){1'b1}}, 1'b0};
   localparam logic [NODE_W-1:0] NODE_LAST = NODE_W'(N-1);
   localparam logic [4:0]        ADDR_LAST = 5'(PMU_CNT-1);

   state_t                state;
   state_t                state_nx;
   logic [TIMEOUT_W-1:0]  tmo_cnt;
   logic                  idle_prev;
   logic [NODE_W-1:0]     cur_node;
   logic [4:0]            cur_addr;
   logic                  all_idle;
   logic                  settled;
   logic                  idle_done;
   logic                  tmo_hit;
   logic                  last_res;
   logic                  cmd_fire;
   logic                  node_ok;
   logic [N-1:0]          node_hit;
   logic [63:0]           sel_data;

   assign all_idle  = &idle_i;
   assign settled   = (tmo_cnt >= TIMEOUT_W'(2));
   assign idle_done = settled && all_idle && idle_prev;
   assign tmo_hit   = (tmo_cnt == TMO_LAST);
   assign last_res  = (cur_node == NODE_LAST) &&
                      (cur_addr == ADDR_LAST);
   assign cmd_fire  = cmd_valid_i && cmd_ready_o;

   assign res_node_o = cur_node;
   assign res_addr_o = cur_addr;

   // Decode the command's target node into a one-hot lane select.
   always_comb begin
      node_hit = '0;
      node_ok  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (cmd_node_i == NODE_W'(i)) begin
            node_hit[i] = 1'b1;
            node_ok     = 1'b1;
         end
      end
   end

   // Select the PMU read data of the node currently being dumped.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (cur_node == NODE_W'(i)) begin
            sel_data = pmu_data_i[i];
         end
      end
   end

   // State register.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (go_i) begin
               state_nx = START;
            end
         end
         START: begin
            state_nx = RUN;
         end
         RUN: begin
            if (idle_done || tmo_hit) begin
               state_nx = DUMP_ADDR;
            end
         end
         DUMP_ADDR: begin
            state_nx = DUMP_WAIT;
         end
         DUMP_WAIT: begin
            state_nx = DUMP_OUT;
         end
         DUMP_OUT: begin
            if (res_ready_i) begin
               state_nx = last_res ? DONE : DUMP_ADDR;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State-decoded outputs, including the PMU address lanes.
   always_comb begin
      cmd_ready_o = (state == IDLE) && !go_i;
      start_o     = (state == START);
      busy_o      = (state != IDLE);
      done_o      = (state == DONE);
      res_valid_o = (state == DUMP_OUT);
      pmu_addr_o  = '0;
      if ((state == DUMP_ADDR) || (state == DUMP_WAIT)) begin
         for (int i = 0; i < N; i++) begin
            if (cur_node == NODE_W'(i)) begin
               pmu_addr_o[i] = cur_addr;
            end
         end
      end
   end

   // Loader lanes: one-cycle push with data; idle lanes keep old data.
   always_ff @(posedge aclk) begin
      if (areset) begin
         fifo_push_o <= '0;
         id_o        <= '0;
         write_o     <= '0;
         axlen_o     <= '0;
         err_o       <= 1'b0;
      end else begin
         fifo_push_o <= '0;
         if (cmd_fire) begin
            for (int i = 0; i < N; i++) begin
               if (node_hit[i]) begin
                  fifo_push_o[i] <= 1'b1;
                  id_o[i]        <= cmd_id_i;
                  write_o[i]     <= cmd_write_i;
                  axlen_o[i]     <= cmd_axlen_i;
               end
            end
            if (!node_ok) begin
               err_o <= 1'b1;
            end
         end
      end
   end

   // Run control: depth latch, timeout counter, idle debounce.
   always_ff @(posedge aclk) begin
      if (areset) begin
         req_depth_o <= '0;
         timeout_o   <= 1'b0;
         tmo_cnt     <= '0;
         idle_prev   <= 1'b0;
      end else begin
         if ((state == IDLE) && go_i) begin
            req_depth_o <= req_depth_i;
            timeout_o   <= 1'b0;
         end
         if (state == START) begin
            tmo_cnt <= '0;
         end else if (state == RUN) begin
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
         end
         idle_prev <= (state == RUN) && settled && all_idle;
         if ((state == RUN) && tmo_hit && !idle_done) begin
            timeout_o <= 1'b1;
         end
      end
   end

   // Dump walk: capture PMU data, step (node, addr) on each handshake.
   always_ff @(posedge aclk) begin
      if (areset) begin
         cur_node   <= '0;
         cur_addr   <= '0;
         res_data_o <= '0;
      end else begin
         if (state == START) begin
            cur_node <= '0;
            cur_addr <= '0;
         end
         if (state == DUMP_WAIT) begin
            res_data_o <= sel_data;
         end
         if ((state == DUMP_OUT) && res_ready_i) begin
            if (cur_addr == ADDR_LAST) begin
               cur_addr <= '0;
               if (last_res) begin
                  cur_node <= '0;
               end else begin
                  cur_node <= cur_node + NODE_W'(1);
               end
            end else begin
               cur_addr <= cur_addr + 5'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_noc_load_sequencer.sv
// Bench for noc_load_sequencer: directed steps with randomized commands,
// backpressure and depths, checked against a queue/array level model.
module tb_noc_load_sequencer;

   localparam int N         = 16;
   localparam int NODE_W    = 5;
   localparam int PMU_CNT   = 8;
   localparam int TIMEOUT_W = 6;
   localparam int NRES      = N * PMU_CNT;

   logic                  aclk = 1'b0;
   logic                  areset;
   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic [NODE_W-1:0]     cmd_node_i;
   logic [4:0]            cmd_id_i;
   logic                  cmd_write_i;
   logic [7:0]            cmd_axlen_i;
   logic                  go_i;
   logic [7:0]            req_depth_i;
   logic [7:0]            req_depth_o;
   logic [N-1:0][4:0]     id_o;
   logic [N-1:0]          write_o;
   logic [N-1:0][7:0]     axlen_o;
   logic [N-1:0]          fifo_push_o;
   logic                  start_o;
   logic [N-1:0]          idle_i;
   logic [N-1:0][4:0]     pmu_addr_o;
   logic [N-1:0][63:0]    pmu_data_i;
   logic                  res_valid_o;
   logic                  res_ready_i;
   logic [NODE_W-1:0]     res_node_o;
   logic [4:0]            res_addr_o;
   logic [63:0]           res_data_o;
   logic                  busy_o;
   logic                  done_o;
   logic                  timeout_o;
   logic                  err_o;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0]           salt = 32'h0;
   logic [N-1:0][4:0]     m_id;
   logic [N-1:0]          m_wr;
   logic [N-1:0][7:0]     m_len;
   logic                  m_err;

   always #5 aclk = ~aclk;

   noc_load_sequencer #(
      .N(N), .NODE_W(NODE_W), .PMU_CNT(PMU_CNT), .TIMEOUT_W(TIMEOUT_W)
   ) dut (
      .aclk(aclk), .areset(areset),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_node_i(cmd_node_i), .cmd_id_i(cmd_id_i),
      .cmd_write_i(cmd_write_i), .cmd_axlen_i(cmd_axlen_i),
      .go_i(go_i), .req_depth_i(req_depth_i), .req_depth_o(req_depth_o),
      .id_o(id_o), .write_o(write_o), .axlen_o(axlen_o),
      .fifo_push_o(fifo_push_o), .start_o(start_o), .idle_i(idle_i),
      .pmu_addr_o(pmu_addr_o), .pmu_data_i(pmu_data_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .res_node_o(res_node_o), .res_addr_o(res_addr_o),
      .res_data_o(res_data_o), .busy_o(busy_o), .done_o(done_o),
      .timeout_o(timeout_o), .err_o(err_o)
   );

   // PMU model: one-cycle read latency, value encodes {salt, node, addr}.
   always @(posedge aclk) begin
      for (int i = 0; i < N; i++) begin
         pmu_data_i[i] <= {salt, 16'(i), 16'(pmu_addr_o[i])};
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   task automatic wait_valid;
      int w;
      w = 0;
      while (!res_valid_o && w < 50) begin
         tick();
         w++;
      end
      chk("res_valid_wait", res_valid_o, 1);
   endtask

   // Drains all results in (node, addr) order under random backpressure.
   task automatic run_dump;
      int   got;
      int   cyc;
      int   e_n;
      int   e_a;
      logic r;
      got = 0;
      cyc = 0;
      while (got < NRES && cyc < 4000) begin
         chk("done_early", done_o, 0);
         chk("busy_dump", busy_o, 1);
         if (res_valid_o) begin
            e_n = got / PMU_CNT;
            e_a = got % PMU_CNT;
            chk("res_node", res_node_o, e_n);
            chk("res_addr", res_addr_o, e_a);
            chk("res_data", res_data_o, {salt, 16'(e_n), 16'(e_a)});
         end
         r = 1'($urandom_range(0, 1));
         res_ready_i = r;
         if (r && res_valid_o) got++;
         tick();
         cyc++;
      end
      res_ready_i = 1'b0;
      chk("res_count", got, NRES);
      chk("done_pulse", done_o, 1);
      chk("res_valid_done", res_valid_o, 0);
      tick();
      chk("done_single", done_o, 0);
      chk("busy_after", busy_o, 0);
   endtask

   initial begin
      int               nd;
      logic [4:0]       cid;
      logic             cwr;
      logic [7:0]       clen;
      logic [N-1:0]     exp_push;
      logic [7:0]       depth;
      int               n;

      salt        = $urandom;
      m_id        = '0;
      m_wr        = '0;
      m_len       = '0;
      m_err       = 1'b0;
      areset      = 1'b1;
      cmd_valid_i = 1'b1;
      go_i        = 1'b1;
      cmd_node_i  = '0;
      cmd_id_i    = '0;
      cmd_write_i = 1'b0;
      cmd_axlen_i = '0;
      req_depth_i = 8'd9;
      idle_i      = '0;
      res_ready_i = 1'b0;

      tick();
      tick();
      chk("rst_cmd_ready", cmd_ready_o, 0);
      chk("rst_push", fifo_push_o, 0);
      chk("rst_id", id_o, 0);
      chk("rst_axlen", axlen_o, 0);
      chk("rst_start", start_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_res_valid", res_valid_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_flags", {timeout_o, err_o}, 0);
      chk("rst_depth", req_depth_o, 0);
      chk("rst_pmu_addr", pmu_addr_o, 0);
      chk("rst_res_data", res_data_o, 0);

      areset      = 1'b0;
      cmd_valid_i = 1'b0;
      go_i        = 1'b0;
      #1;
      chk("post_rst_ready", cmd_ready_o, 1);
      chk("post_rst_busy", busy_o, 0);

      for (int k = 0; k < 10; k++) begin
         unique case (k)
            0: begin nd = 2;  cid = 5'h3; cwr = 1'b1; clen = 8'd7; end
            1: begin nd = 2;  cid = 5'h4; cwr = 1'b0; clen = 8'd0; end
            2: begin nd = 15; cid = 5'h1; cwr = 1'b0; clen = 8'd3; end
            3: begin nd = 16; cid = 5'h9; cwr = 1'b1; clen = 8'd2; end
            default: begin
               nd   = $urandom_range(0, N);
               cid  = 5'($urandom);
               cwr  = 1'($urandom);
               clen = 8'($urandom);
            end
         endcase
         cmd_valid_i = 1'b1;
         cmd_node_i  = NODE_W'(nd);
         cmd_id_i    = cid;
         cmd_write_i = cwr;
         cmd_axlen_i = clen;
         #1;
         chk("cmd_ready", cmd_ready_o, 1);
         exp_push = '0;
         if (nd < N) begin
            exp_push[nd] = 1'b1;
            m_id[nd]     = cid;
            m_wr[nd]     = cwr;
            m_len[nd]    = clen;
         end else begin
            m_err = 1'b1;
         end
         tick();
         chk("push", fifo_push_o, exp_push);
         chk("lane_id", id_o, m_id);
         chk("lane_write", write_o, m_wr);
         chk("lane_axlen", axlen_o, m_len);
         chk("err", err_o, m_err);
      end

      cmd_valid_i = 1'b1;
      cmd_node_i  = NODE_W'(3);
      go_i        = 1'b1;
      req_depth_i = 8'd4;
      #1;
      chk("go_cmd_ready", cmd_ready_o, 0);
      tick();
      go_i        = 1'b0;
      cmd_valid_i = 1'b0;
      chk("start_pulse", start_o, 1);
      chk("go_no_push", fifo_push_o, 0);
      chk("req_depth", req_depth_o, 4);
      chk("busy_start", busy_o, 1);
      tick();
      chk("start_once", start_o, 0);
      for (int k = 0; k < 50; k++) begin
         tick();
         chk("run_no_valid", res_valid_o, 0);
         chk("run_no_done", done_o, 0);
      end
      idle_i = '1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("idle_settle", res_valid_o, 0);
      end
      tick();
      chk("dump_entry", res_valid_o, 1);
      run_dump();
      chk("no_timeout", timeout_o, 0);
      chk("err_sticky", err_o, m_err);

      idle_i      = '1;
      idle_i[7]   = 1'b0;
      depth       = 8'($urandom);
      req_depth_i = depth;
      go_i        = 1'b1;
      tick();
      go_i = 1'b0;
      chk("tmo_start", start_o, 1);
      chk("tmo_depth", req_depth_o, depth);
      tick();
      n = 0;
      while (!timeout_o && n < 200) begin
         tick();
         n++;
      end
      chk("tmo_cycles", n, (1 << TIMEOUT_W) - 1);
      wait_valid();
      run_dump();
      chk("tmo_sticky", timeout_o, 1);

      idle_i = '1;
      go_i   = 1'b1;
      tick();
      go_i = 1'b0;
      chk("tmo_clear", timeout_o, 0);
      chk("start_again", start_o, 1);
      wait_valid();
      areset = 1'b1;
      tick();
      chk("rst_mid_valid", res_valid_o, 0);
      chk("rst_mid_done", done_o, 0);
      chk("rst_mid_busy", busy_o, 0);
      chk("rst_mid_err", err_o, 0);
      chk("rst_mid_depth", req_depth_o, 0);
      areset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("post_rst_done", done_o, 0);
         chk("post_rst_idle", busy_o, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
